cmd_dispatch_queue: RTL

Parametrised successor of the UART command decoder: accepts command bytes from the UART receive path, buffers them in a small FIFO so the host can stream several commands back-to-back, and dispatches each to the read and/or write arbiter over proper valid/ready channels. Adds illegal-command detection, FIFO overflow detection, an arbiter-ack timeout and sticky error reporting. Sits between the UART receiver and the DMI read/write arbiters.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 51 +++++
 rtl/cmd_dispatch_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART command path: command/address widths, command
// codes, error-bit positions and the dispatcher state type.
package uart_pkg;

  localparam int CMDLENGTH = 3;
  localparam int IRLENGTH  = 5;

  localparam logic [CMDLENGTH-1:0] CMD_NOP       = 3'b000;
  localparam logic [CMDLENGTH-1:0] CMD_RESET     = 3'b001;
  localparam logic [CMDLENGTH-1:0] CMD_READ      = 3'b010;
  localparam logic [CMDLENGTH-1:0] CMD_CONT_READ = 3'b011;
  localparam logic [CMDLENGTH-1:0] CMD_WRITE     = 3'b100;

  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;

  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_ILLEGAL  = 1;
  localparam int ERR_TIMEOUT  = 2;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } dispatch_state_t;

  function automatic logic is_legal_cmd(input logic [CMDLENGTH-1:0] cmd);
    return cmd inside {CMD_RESET, CMD_READ, CMD_CONT_READ, CMD_WRITE};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head view; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cmd_dispatch_queue.sv
// Queues UART command bytes and dispatches each to the read and/or write
// arbiter over valid/ready, with sticky overflow/illegal/timeout errors.
module cmd_dispatch_queue
  import uart_pkg::*;
#(
  parameter int CMD_WIDTH      = CMDLENGTH,
  parameter int ADDR_WIDTH     = IRLENGTH,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            CLK_I,
  input  logic                            RST_I,
  input  logic                            READ_I,
  input  logic                            CMD_REC_I,
  input  logic [CMD_WIDTH+ADDR_WIDTH-1:0] DATA_REC_I,
  output logic                            BUSY_O,
  output logic [$clog2(DEPTH+1)-1:0]      COUNT_O,
  output logic                            READ_VALID_O,
  input  logic                            READ_READY_I,
  output logic [CMD_WIDTH-1:0]            READ_COMMAND_O,
  output logic [ADDR_WIDTH-1:0]           READ_ADDRESS_O,
  output logic                            WRITE_VALID_O,
  input  logic                            WRITE_READY_I,
  output logic [CMD_WIDTH-1:0]            WRITE_COMMAND_O,
  output logic [ADDR_WIDTH-1:0]           WRITE_ADDRESS_O,
  output logic [2:0]                      ERROR_O,
  input  logic                            ERROR_CLR_I
);
  localparam int BW = CMD_WIDTH + ADDR_WIDTH;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  dispatch_state_t       state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q, head_cmd, in_cmd;
  logic [ADDR_WIDTH-1:0] addr_q, head_addr;
  logic [BW-1:0]         head;
  logic [TW-1:0]         tmo_q;
  logic [2:0]            err_q, err_set;
  logic rd_done_q, wr_done_q, need_rd, need_wr, rd_act, wr_act, rd_hs, wr_hs;
  logic fifo_full, fifo_empty, push_req, push, pop, load, all_done, timeout_hit;

  assign in_cmd    = DATA_REC_I[BW-1 -: CMD_WIDTH];
  assign push_req  = READ_I && CMD_REC_I && (in_cmd != CMD_NOP);
  assign pop       = (state_q == ST_IDLE) && !fifo_empty;
  assign push      = push_req && (!fifo_full || pop);
  assign head_cmd  = head[BW-1 -: CMD_WIDTH];
  assign head_addr = head[ADDR_WIDTH-1:0];
  assign load      = pop && is_legal_cmd(head_cmd);

  sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo (
    .clk  (CLK_I),
    .rst  (RST_I),
    .push (push),
    .pop  (pop),
    .data (DATA_REC_I),
    .head (head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(COUNT_O)
  );

  assign BUSY_O = fifo_full;

  assign need_rd  = cmd_q inside {CMD_READ, CMD_CONT_READ, CMD_RESET};
  assign need_wr  = cmd_q inside {CMD_WRITE, CMD_RESET};
  assign rd_act   = (state_q == ST_ISSUE) && need_rd && !rd_done_q;
  assign wr_act   = (state_q == ST_ISSUE) && need_wr && !wr_done_q;
  assign rd_hs    = rd_act && READ_READY_I;
  assign wr_hs    = wr_act && WRITE_READY_I;
  assign all_done = (!need_rd || rd_done_q || rd_hs) && (!need_wr || wr_done_q || wr_hs);
  // Fires on the last permitted ISSUE cycle so valid is high exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state_q == ST_ISSUE) &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    READ_VALID_O    = 1'b0;
    READ_COMMAND_O  = CMD_NOP;
    READ_ADDRESS_O  = '0;
    WRITE_VALID_O   = 1'b0;
    WRITE_COMMAND_O = CMD_NOP;
    WRITE_ADDRESS_O = '0;
    case (state_q)
      ST_IDLE: if (load) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (rd_act) begin
          READ_VALID_O   = 1'b1;
          READ_COMMAND_O = cmd_q;
          READ_ADDRESS_O = addr_q;
        end
        if (wr_act) begin
          WRITE_VALID_O   = 1'b1;
          WRITE_COMMAND_O = cmd_q;
          WRITE_ADDRESS_O = (cmd_q == CMD_RESET) ? ADDR_IDCODE : addr_q;
        end
        if (all_done || timeout_hit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      cmd_q     <= CMD_NOP;
      addr_q    <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      tmo_q     <= '0;
    end else if (load) begin
      cmd_q     <= head_cmd;
      addr_q    <= head_addr;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      tmo_q     <= '0;
    end else if (state_q == ST_ISSUE) begin
      rd_done_q <= rd_done_q | rd_hs;
      wr_done_q <= wr_done_q | wr_hs;
      if (TIMEOUT_CYCLES > 0) tmo_q <= tmo_q + TW'(1);
    end
  end

  always_comb begin
    err_set               = '0;
    err_set[ERR_OVERFLOW] = push_req && fifo_full && !pop;
    err_set[ERR_ILLEGAL]  = pop && !is_legal_cmd(head_cmd);
    err_set[ERR_TIMEOUT]  = timeout_hit && !all_done;
  end

  // A new event in the clearing cycle survives the clear.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) err_q <= '0;
    else       err_q <= (ERROR_CLR_I ? 3'b000 : err_q) | err_set;
  end

  assign ERROR_O = err_q;

endmodule
